// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: entropy-coder back end.
// Packs right-aligned codewords MSB-first into a 64-bit accumulator and
// hands out 32-bit words with per-byte "nostuff" flags for the byte-stuffing
// stage. Markers are byte-aligned with one-bit padding. A flush pads to a
// byte boundary with one-bits, then to a word boundary with flagged 0xFF
// bytes.
// Optional feature macro: JPEG_BIT_PACKER_BYTECNT_EN adds the byte_count
// output, a running count of emitted bytes.

module jpeg_bit_packer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_nostuff,
  input  logic               in_flush,
  input  logic               out_ready,
  output logic               enqueue,
  output logic [31:0]        wdata,
`ifdef JPEG_BIT_PACKER_BYTECNT_EN
  output logic [31:0]        wdata_nostuff,
  output logic [31:0]        byte_count
`else
  output logic [31:0]        wdata_nostuff
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [63:0] ONES = '1;

  state_t      state, stateNext;
  logic [63:0] acc, accNext;
  logic [7:0]  nflag, nflagNext;
  logic [6:0]  fill, fillNext;
  logic        started;
  logic        emit;

  logic [6:0]  lenExt;
  logic [63:0] codeBits;
  logic [2:0]  padCnt;
  logic [6:0]  fillAligned;
  logic [63:0] markPadMask;
  logic [63:0] flushMask;

  // Shared arithmetic: masked codeword, padding count to the next byte
  // boundary, and the one-bit masks used for marker and flush padding.
  always_comb begin
    lenExt      = 7'(in_len);
    codeBits    = 64'(in_code) & ~(ONES << lenExt);
    padCnt      = 3'd0 - fill[2:0];
    fillAligned = fill + 7'(padCnt);
    markPadMask = (ONES >> fill) & ~(ONES >> fillAligned);
    flushMask   = (ONES >> fill) & ~(ONES >> 7'd32);
  end

  // Accept only in IDLE with room for another word; held low until the
  // first clock edge after reset release.
  always_comb begin
    in_ready = started && (state == IDLE) && (fill < 7'd32);
    emit     = (fill >= 7'd32) && out_ready;
  end

  // Next-state logic: emitting takes priority; otherwise IDLE appends codes
  // and FLUSH pads the tail out to a full word and then drains it.
  always_comb begin
    stateNext = state;
    accNext   = acc;
    nflagNext = nflag;
    fillNext  = fill;
    if (emit) begin
      accNext   = acc << 32;
      nflagNext = nflag << 4;
      fillNext  = fill - 7'd32;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_flush) begin
              stateNext = FLUSH;
            end else if (in_nostuff) begin
              accNext  = acc | markPadMask |
                         (codeBits << (7'd64 - fillAligned - lenExt));
              fillNext = fillAligned + lenExt;
              for (int b = 0; b < 8; b++) begin
                if ((b * 8 >= int'(fillAligned)) &&
                    (b * 8 < int'(fillAligned) + int'(lenExt)))
                  nflagNext[3'(7 - b)] = 1'b1;
              end
            end else begin
              accNext  = acc | (codeBits << (7'd64 - fill - lenExt));
              fillNext = fill + lenExt;
            end
          end
        end
        FLUSH: begin
          if (fill == 7'd0) begin
            stateNext = IDLE;
          end else if (fill < 7'd32) begin
            accNext  = acc | flushMask;
            fillNext = 7'd32;
            for (int b = 0; b < 4; b++) begin
              if (b * 8 >= int'(fillAligned))
                nflagNext[3'(7 - b)] = 1'b1;
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      nflag   <= '0;
      fill    <= '0;
      started <= 1'b0;
    end else begin
      state   <= stateNext;
      acc     <= accNext;
      nflag   <= nflagNext;
      fill    <= fillNext;
      started <= 1'b1;
    end
  end

  // Registered output word; byte k of wdata is flagged through bit 8k+7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enqueue       <= 1'b0;
      wdata         <= '0;
      wdata_nostuff <= '0;
    end else begin
      enqueue <= emit;
      if (emit) begin
        wdata         <= acc[63:32];
        wdata_nostuff <= {nflag[7], 7'd0, nflag[6], 7'd0,
                          nflag[5], 7'd0, nflag[4], 7'd0};
      end
    end
  end

`ifdef JPEG_BIT_PACKER_BYTECNT_EN
  // Running byte count, updated on the same edge that raises enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      byte_count <= '0;
    else if (emit)
      byte_count <= byte_count + 32'd4;
  end
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: scoreboard bench for jpeg_bit_packer.
// Expected {wdata, wdata_nostuff} pairs are queued as stimulus completes a
// word and are compared when the DUT raises enqueue.

module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_nostuff = 1'b0;
  logic        in_flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        enqueue;
  logic [31:0] wdata;
  logic [31:0] wdata_nostuff;
`ifdef JPEG_BIT_PACKER_BYTECNT_EN
  logic [31:0] byte_count;
`endif

  int checks = 0;
  int errors = 0;
  int enqCount = 0;
  logic [63:0] sb[$];

  jpeg_bit_packer #(.MAX_LEN(32), .LEN_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .in_len(in_len),
    .in_nostuff(in_nostuff),
    .in_flush(in_flush),
    .out_ready(out_ready),
    .enqueue(enqueue),
    .wdata(wdata),
`ifdef JPEG_BIT_PACKER_BYTECNT_EN
    .wdata_nostuff(wdata_nostuff),
    .byte_count(byte_count)
`else
    .wdata_nostuff(wdata_nostuff)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one codeword or command, waiting a bounded time for in_ready.
  task automatic applyStimulus(input logic [31:0] code, input int len,
                               input logic nostuff, input logic flush);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("readyTimeout", 64'(in_ready), 64'd1);
    end else begin
      in_code    = code;
      in_len     = 6'(len);
      in_nostuff = nostuff;
      in_flush   = flush;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_nostuff = 1'b0;
      in_flush   = 1'b0;
    end
  endtask

  // Wait a bounded time for every queued word to come out.
  task automatic waitDrain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pop and compare every emitted word.
  always @(negedge clk) begin
    if (rst_n && enqueue) begin
      enqCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpectedWord", {wdata, wdata_nostuff}, 64'd0 - 64'd1);
      end else begin
        checkOutput("word", {wdata, wdata_nostuff}, sb.pop_front());
      end
`ifdef JPEG_BIT_PACKER_BYTECNT_EN
      checkOutput("byteCount", 64'(byte_count), 64'(4 * enqCount));
`endif
    end
  end

  initial begin
    int gotReady;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstEnqueue", 64'(enqueue), 64'd0);
    checkOutput("rstWdata", 64'(wdata), 64'd0);
    checkOutput("rstNostuff", 64'(wdata_nostuff), 64'd0);
    checkOutput("rstInReady", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", 64'(in_ready), 64'd1);

    // Four byte codes form one plain word
    applyStimulus(32'hAB, 8, 1'b0, 1'b0);
    applyStimulus(32'hCD, 8, 1'b0, 1'b0);
    applyStimulus(32'hEF, 8, 1'b0, 1'b0);
    applyStimulus(32'h01, 8, 1'b0, 1'b0);
    sb.push_back({32'hABCDEF01, 32'h0});
    waitDrain("drainBytes");

    // Odd lengths, upper code bits ignored
    applyStimulus(32'hFFFF_FFFD, 3, 1'b0, 1'b0);
    applyStimulus(32'h1FFF_FFFF, 29, 1'b0, 1'b0);
    sb.push_back({32'hBFFFFFFF, 32'h0});
    waitDrain("drainOdd");

    // Marker after partial byte, then flush
    applyStimulus(32'h5, 3, 1'b0, 1'b0);
    applyStimulus(32'hFFD9, 16, 1'b1, 1'b0);
    applyStimulus(32'h0, 0, 1'b0, 1'b1);
    sb.push_back({32'hBFFFD9FF, 32'h00808080});
    waitDrain("drainMarker");
    checkOutput("idleAfterFlush", 64'(in_ready), 64'd1);

    // Backpressure with 40 bits held
    out_ready = 1'b0;
    applyStimulus(32'hAA, 8, 1'b0, 1'b0);
    applyStimulus(32'hDEADBEEF, 32, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("holdInReady", 64'(in_ready), 64'd0);
      checkOutput("holdEnqueue", 64'(enqueue), 64'd0);
    end
    sb.push_back({32'hAADEADBE, 32'h0});
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("releaseEnqueue", 64'(enqueue), 64'd1);
    checkOutput("releaseInReady", 64'(in_ready), 64'd1);
    applyStimulus(32'h0, 0, 1'b0, 1'b1);
    sb.push_back({32'hEFFFFFFF, 32'h00808080});
    waitDrain("drainBackpressure");

    // Reset discards partial data
    applyStimulus(32'hABCDE, 20, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstEnqueue", 64'(enqueue), 64'd0);
    rst_n = 1'b1;
    enqCount = 0;
    applyStimulus(32'h12345678, 32, 1'b0, 1'b0);
    sb.push_back({32'h12345678, 32'h0});
    waitDrain("drainAfterReset");

    // Flush on an empty accumulator
    applyStimulus(32'h0, 0, 1'b0, 1'b1);
    gotReady = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("emptyFlushEnqueue", 64'(enqueue), 64'd0);
      if (in_ready) gotReady = 1;
    end
    checkOutput("emptyFlushReady", 64'(gotReady), 64'd1);
    waitDrain("drainFinal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
